// File: rtl/rtc_field_editor.sv
// ---------------------------------------------------------------------------
// rtc_field_editor
//
// Purpose
//   N-field BCD editor for RTC set-up screens (date, time, alarm). A cursor
//   walks over NFIELDS register fields with left/right. Pressing up/down
//   changes the selected field with BCD wrap between per-field limits. Each
//   edit writes that field to the RTC bus controller. The write is an address
//   phase followed by a data phase, and each phase waits for bus_ack.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   enable                  editor active; low returns to IDLE
//   up, down, left, right   1-cycle button pulses from the debouncers
//   load_valid/idx/data     preload from the RTC read sequencer
//   bus_ack                 bus controller accepted the current phase
//   cursor_o                selected field index
//   fields_o                packed BCD field values, field i at [8i+7:8i]
//   bus_req/ad/wr/data      write request, phase (0=addr, 1=data), write, payload
//   busy                    write in flight; edits and navigation ignored
//   done, err               1-cycle pulses: write completed / ack timeout
// ---------------------------------------------------------------------------
module rtc_field_editor #(
    parameter int                   NFIELDS     = 3,
    parameter logic [7:0]           BASE_ADDR   = 8'h24,
    parameter logic [7:0]           ADDR_STEP   = 8'h01,
    parameter logic [8*NFIELDS-1:0] MIN_PACKED  = 24'h00_01_01,
    parameter logic [8*NFIELDS-1:0] MAX_PACKED  = 24'h99_12_31,
    parameter int                   ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   load_valid,
    input  logic [2:0]             load_idx,
    input  logic [7:0]             load_data,
    input  logic                   bus_ack,
    output logic [2:0]             cursor_o,
    output logic [8*NFIELDS-1:0]   fields_o,
    output logic                   bus_req,
    output logic                   bus_ad,
    output logic                   bus_wr,
    output logic [7:0]             bus_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [2:0] LAST_IDX = 3'(NFIELDS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cursor_q, cursor_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic [7:0]    field_q [NFIELDS];
    logic [7:0]    field_d [NFIELDS];

    // Selected-field view, shared by the edit path and the data phase.
    logic [7:0] sel_val, sel_min, sel_max;
    logic [7:0] ld_min, ld_max, ld_val;
    logic [7:0] edit_val;
    logic [7:0] field_addr;
    logic       edit_req, move_req, load_ok, in_phase, ack_expire;

    // Two-digit BCD increment. Values stay valid BCD because loads are
    // sanitised, so only the 9->0 carry needs handling.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] hi, lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo >= 4'd9) begin
            lo = 4'd0;
            hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] hi, lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd0) begin
            lo = 4'd9;
            hi = (hi == 4'd0) ? 4'd9 : hi - 4'd1;
        end else begin
            lo = lo - 4'd1;
        end
        return {hi, lo};
    endfunction

    // Index muxes are written as loops over constant indices, so an
    // out-of-range 3-bit index simply matches no field.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        sel_val = '0;
        sel_min = '0;
        sel_max = '0;
        ld_min  = '0;
        ld_max  = '0;
        for (int i = 0; i < NFIELDS; i++) begin
            if (cursor_q == 3'(i)) begin
                sel_val = field_q[i];
                sel_min = MIN_PACKED[8*i +: 8];
                sel_max = MAX_PACKED[8*i +: 8];
            end
            if (load_idx == 3'(i)) begin
                ld_min = MIN_PACKED[8*i +: 8];
                ld_max = MAX_PACKED[8*i +: 8];
            end
        end
    end

    // Wrap between the field limits. This limit check takes priority over
    // the plain BCD step.
    always_comb begin
        if (up) begin
            edit_val = (sel_val == sel_max) ? sel_min : bcd_inc(sel_val);
        end else begin
            edit_val = (sel_val == sel_min) ? sel_max : bcd_dec(sel_val);
        end
    end

    // Loads with a non-BCD digit or a value outside [min,max] fall back to
    // min. Range is compared as binary, which orders valid BCD correctly.
    always_comb begin
        if (load_data[7:4] <= 4'd9 && load_data[3:0] <= 4'd9 &&
            load_data >= ld_min && load_data <= ld_max) begin
            ld_val = load_data;
        end else begin
            ld_val = ld_min;
        end
    end

    assign field_addr = BASE_ADDR + ({5'd0, cursor_q} * ADDR_STEP);

    assign edit_req   = enable && (state_q == S_EDIT) && (up ^ down);
    assign move_req   = enable && (state_q == S_EDIT) && !edit_req && (left ^ right);
    assign load_ok    = load_valid && (load_idx <= LAST_IDX) &&
                        (state_q == S_IDLE || state_q == S_EDIT);
    assign in_phase   = (state_q == S_ADDR) || (state_q == S_DATA);
    assign ack_expire = in_phase && !bus_ack && (timer_q == TIMER_LAST);

    // Next-state, cursor, timer and field update.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        timer_d  = '0;
        err_d    = 1'b0;
        for (int i = 0; i < NFIELDS; i++) begin
            field_d[i] = field_q[i];
        end

        case (state_q)
            S_IDLE: if (enable) state_d = S_EDIT;
            S_EDIT: if (edit_req) state_d = S_ADDR;
            S_ADDR: begin
                if (bus_ack)         state_d = S_DATA;
                else if (ack_expire) state_d = S_EDIT;
            end
            S_DATA: begin
                if (bus_ack)         state_d = S_DONE;
                else if (ack_expire) state_d = S_EDIT;
            end
            S_DONE:  state_d = S_EDIT;
            default: state_d = S_IDLE;
        endcase

        // The timer restarts on every phase change and after an abort.
        if (in_phase && !bus_ack && !ack_expire) begin
            timer_d = timer_q + TW'(1);
        end

        if (move_req) begin
            if (right) cursor_d = (cursor_q == LAST_IDX) ? 3'd0 : cursor_q + 3'd1;
            else       cursor_d = (cursor_q == 3'd0) ? LAST_IDX : cursor_q - 3'd1;
        end

        // The load goes first so an edit of the same field overrides it.
        for (int i = 0; i < NFIELDS; i++) begin
            if (load_ok && load_idx == 3'(i))   field_d[i] = ld_val;
            if (edit_req && cursor_q == 3'(i))  field_d[i] = edit_val;
        end

        err_d = ack_expire && enable;

        // Dropping enable aborts any write quietly and parks the cursor.
        if (!enable) begin
            state_d  = S_IDLE;
            cursor_d = 3'd0;
            timer_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cursor_q <= 3'd0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            // NOTE: this small register file is reset on purpose, because
            // every field must read as its minimum after reset.
            for (int i = 0; i < NFIELDS; i++) begin
                field_q[i] <= MIN_PACKED[8*i +: 8];
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment only, so
            // every register samples the values from before the edge.
            state_q  <= state_d;
            cursor_q <= cursor_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            for (int i = 0; i < NFIELDS; i++) begin
                field_q[i] <= field_d[i];
            end
        end
    end

    always_comb begin
        fields_o = '0;
        for (int i = 0; i < NFIELDS; i++) begin
            fields_o[8*i +: 8] = field_q[i];
        end
    end

    assign cursor_o = cursor_q;
    assign bus_req  = in_phase;
    assign bus_wr   = in_phase;
    assign bus_ad   = (state_q == S_DATA);
    assign bus_data = (state_q == S_ADDR) ? field_addr :
                      (state_q == S_DATA) ? sel_val    : 8'h00;
    assign busy     = in_phase || (state_q == S_DONE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
// ---------------------------------------------------------------------------
// tb_rtc_field_editor
//
// Bench for rtc_field_editor with the default 3-field date layout. A
// decimal-arithmetic model of the fields and the cursor gives the expected
// values. Directed scenarios come first, then a randomized walk.
// ---------------------------------------------------------------------------
module tb_rtc_field_editor;

    localparam int NF  = 3;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          reset, enable, up, down, left, right;
    logic          load_valid, bus_ack;
    logic [2:0]    load_idx;
    logic [7:0]    load_data;
    logic [2:0]    cursor_o;
    logic [8*NF-1:0] fields_o;
    logic          bus_req, bus_ad, bus_wr, busy, done, err;
    logic [7:0]    bus_data;

    int total = 0;
    int bad   = 0;

    // Model state: field values as BCD bytes held in ints, plus the cursor.
    int m_field [NF];
    int m_cursor;
    int fmin [NF] = '{8'h01, 8'h01, 8'h00};
    int fmax [NF] = '{8'h31, 8'h12, 8'h99};

    rtc_field_editor #(.NFIELDS(NF), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .up(up), .down(down), .left(left), .right(right),
        .load_valid(load_valid), .load_idx(load_idx), .load_data(load_data),
        .bus_ack(bus_ack), .cursor_o(cursor_o), .fields_o(fields_o),
        .bus_req(bus_req), .bus_ad(bus_ad), .bus_wr(bus_wr), .bus_data(bus_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int to_dec(input int b);
        return (b >> 4) * 10 + (b & 15);
    endfunction

    function automatic int to_bcd(input int d);
        return ((d / 10) << 4) | (d % 10);
    endfunction

    function automatic int m_up(input int i, input int v);
        return (v == fmax[i]) ? fmin[i] : to_bcd(to_dec(v) + 1);
    endfunction

    function automatic int m_down(input int i, input int v);
        return (v == fmin[i]) ? fmax[i] : to_bcd(to_dec(v) - 1);
    endfunction

    function automatic int m_sanitize(input int i, input int v);
        if ((v >> 4) > 9 || (v & 15) > 9) return fmin[i];
        if (to_dec(v) < to_dec(fmin[i]) || to_dec(v) > to_dec(fmax[i])) return fmin[i];
        return v;
    endfunction

    function automatic logic [8*NF-1:0] m_packed();
        logic [8*NF-1:0] p;
        for (int i = 0; i < NF; i++) p[8*i +: 8] = 8'(m_field[i]);
        return p;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NF; i++) m_field[i] = fmin[i];
        m_cursor = 0;
    endtask

    task automatic idle_inputs();
        up = 0; down = 0; left = 0; right = 0;
        load_valid = 0; load_idx = 0; load_data = 0; bus_ack = 0;
    endtask

    task automatic pulse(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
        step();
        up = 0; down = 0; left = 0; right = 0;
    endtask

    task automatic do_load(input int idx, input int val);
        load_valid = 1; load_idx = 3'(idx); load_data = 8'(val);
        step();
        load_valid = 0;
        if (idx < NF) m_field[idx] = m_sanitize(idx, val);
    endtask

    // Called just after the edge that accepted an edit. Drives both ack
    // handshakes with the given delays and checks every phase on the way.
    task automatic run_write(input int d1, input int d2, input string tag);
        logic [7:0] ea, ed;
        ea = 8'(8'h24 + m_cursor);
        ed = 8'(m_field[m_cursor]);
        repeat (d1) step();
        total++;
        if ({bus_req, bus_wr, bus_ad, busy} !== 4'b1101 || bus_data !== ea) begin
            bad++;
            $display("FAIL %s addr phase: req/wr/ad/busy=%b data=%h, want 1101 %h",
                     tag, {bus_req, bus_wr, bus_ad, busy}, bus_data, ea);
        end
        bus_ack = 1; step(); bus_ack = 0;
        repeat (d2) step();
        total++;
        if ({bus_req, bus_wr, bus_ad, busy} !== 4'b1111 || bus_data !== ed) begin
            bad++;
            $display("FAIL %s data phase: req/wr/ad/busy=%b data=%h, want 1111 %h",
                     tag, {bus_req, bus_wr, bus_ad, busy}, bus_data, ed);
        end
        bus_ack = 1; step(); bus_ack = 0;
        total++;
        if ({done, bus_req, busy} !== 3'b101) begin
            bad++;
            $display("FAIL %s done: done/req/busy=%b want 101", tag, {done, bus_req, busy});
        end
        step();
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL %s after done: done/busy=%b want 00", tag, {done, busy});
        end
    endtask

    task automatic check_view(input string tag);
        total++;
        if (fields_o !== m_packed() || cursor_o !== 3'(m_cursor)) begin
            bad++;
            $display("FAIL %s view: fields=%h cursor=%0d, want fields=%h cursor=%0d",
                     tag, fields_o, cursor_o, m_packed(), m_cursor);
        end
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; idle_inputs();
        step(); step();
        reset = 0;
        m_reset();
        check_view("reset");
        total++;
        if ({bus_req, bus_ad, bus_wr, bus_data, busy, done, err} !== 13'd0) begin
            bad++;
            $display("FAIL reset outputs: got %b want 0",
                     {bus_req, bus_ad, bus_wr, bus_data, busy, done, err});
        end
    endtask

    task automatic test_first_write();
        enable = 1; step();
        pulse(1, 0, 0, 0);
        m_field[0] = m_up(0, m_field[0]);
        check_view("first_write");
        total++;
        if (fields_o[7:0] !== 8'h02) begin
            bad++;
            $display("FAIL first_write field0: got %h want 02", fields_o[7:0]);
        end
        run_write(0, 0, "first_write");
    endtask

    task automatic test_loads_and_wrap();
        do_load(0, 8'h31);
        pulse(1, 0, 0, 0); m_field[0] = m_up(0, m_field[0]);
        check_view("wrap_up_f0");
        run_write(1, 0, "wrap_up_f0");
        do_load(1, 8'h01);
        pulse(0, 0, 0, 1); m_cursor = 1;
        pulse(0, 1, 0, 0); m_field[1] = m_down(1, m_field[1]);
        check_view("wrap_down_f1");
        run_write(0, 2, "wrap_down_f1");
        do_load(2, 8'h09);
        pulse(0, 0, 0, 1); m_cursor = 2;
        pulse(1, 0, 0, 0); m_field[2] = m_up(2, m_field[2]);
        check_view("carry_f2");
        run_write(0, 0, "carry_f2");
        total++;
        if (fields_o !== 24'h10_12_01) begin
            bad++;
            $display("FAIL loads_and_wrap fields: got %h want 101201", fields_o);
        end
    endtask

    task automatic test_cursor_wrap();
        pulse(0, 0, 0, 1); m_cursor = 0;
        check_view("right_wrap");
        pulse(0, 0, 1, 0); m_cursor = NF - 1;
        check_view("left_wrap");
        total++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cursor_move bus: req=%b busy=%b want 0 0", bus_req, busy);
        end
        pulse(0, 0, 0, 1); m_cursor = 0;
        check_view("right_wrap2");
    endtask

    task automatic test_simultaneous();
        pulse(1, 1, 0, 0);
        check_view("up_down");
        total++;
        if (bus_req !== 1'b0) begin
            bad++;
            $display("FAIL up_down bus_req: got %b want 0", bus_req);
        end
        pulse(0, 0, 1, 1);
        check_view("left_right");
        pulse(1, 0, 0, 1); m_field[m_cursor] = m_up(m_cursor, m_field[m_cursor]);
        check_view("up_right");
        run_write(0, 0, "up_right");
        // Load and edit of the same field: the edit result must win.
        load_valid = 1; load_idx = 3'(m_cursor); load_data = 8'h07;
        pulse(0, 1, 0, 0);
        load_valid = 0;
        m_field[m_cursor] = m_down(m_cursor, m_field[m_cursor]);
        check_view("load_vs_edit");
        run_write(0, 0, "load_vs_edit");
    endtask

    task automatic test_timeout();
        int n;
        pulse(1, 0, 0, 0); m_field[m_cursor] = m_up(m_cursor, m_field[m_cursor]);
        n = 0;
        while (bus_req === 1'b1 && n < TMO + 10) begin
            n++;
            step();
        end
        total++;
        if (n !== TMO || err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout: req cycles=%0d err=%b busy=%b, want %0d 1 0",
                     n, err, busy, TMO);
        end
        check_view("timeout_keep");
        step();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout err width: got %b want 0", err);
        end
        // Still in EDIT: a further edit must start a write.
        pulse(0, 1, 0, 0); m_field[m_cursor] = m_down(m_cursor, m_field[m_cursor]);
        run_write(0, 0, "after_timeout");
    endtask

    task automatic test_enable_drop();
        pulse(0, 0, 0, 1); m_cursor = (m_cursor + 1) % NF;
        pulse(1, 0, 0, 0); m_field[m_cursor] = m_up(m_cursor, m_field[m_cursor]);
        bus_ack = 1; step(); bus_ack = 0;
        enable = 0; step();
        m_cursor = 0;
        total++;
        if ({bus_req, busy, done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL enable_drop: req/busy/done/err=%b want 0000",
                     {bus_req, busy, done, err});
        end
        step();
        total++;
        if ({done, err} !== 2'b00) begin
            bad++;
            $display("FAIL enable_drop later: done/err=%b want 00", {done, err});
        end
        check_view("enable_drop");
        enable = 1; step();
    endtask

    task automatic test_reset_mid_write();
        pulse(1, 0, 0, 0);
        reset = 1; step(); reset = 0;
        m_reset();
        check_view("reset_mid");
        total++;
        if ({bus_req, bus_ad, bus_wr, bus_data, busy, done, err} !== 13'd0) begin
            bad++;
            $display("FAIL reset_mid outputs: got %b want 0",
                     {bus_req, bus_ad, bus_wr, bus_data, busy, done, err});
        end
        step();
    endtask

    task automatic test_bad_load();
        do_load(0, 8'h15);
        check_view("load_ok");
        do_load(0, 8'h3A);
        check_view("load_3A");
        do_load(0, 8'h20);
        do_load(0, 8'h45);
        check_view("load_45");
        total++;
        if (fields_o[7:0] !== 8'h01) begin
            bad++;
            $display("FAIL load_45 field0: got %h want 01", fields_o[7:0]);
        end
        do_load(3, 8'h05);
        do_load(7, 8'h05);
        check_view("load_idx_range");
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            int op, li, lv;
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: begin
                    pulse(op == 0, op == 1, 0, 0);
                    if (op == 0) m_field[m_cursor] = m_up(m_cursor, m_field[m_cursor]);
                    else         m_field[m_cursor] = m_down(m_cursor, m_field[m_cursor]);
                    check_view("rand_edit");
                    run_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand_edit");
                end
                2: begin
                    pulse(0, 0, 1, 0);
                    m_cursor = (m_cursor == 0) ? NF - 1 : m_cursor - 1;
                    check_view("rand_left");
                end
                3: begin
                    pulse(0, 0, 0, 1);
                    m_cursor = (m_cursor + 1) % NF;
                    check_view("rand_right");
                end
                default: begin
                    li = int'($urandom_range(0, NF));
                    lv = int'($urandom_range(0, 255));
                    do_load(li, lv);
                    check_view("rand_load");
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_loads_and_wrap();
        test_cursor_wrap();
        test_simultaneous();
        test_timeout();
        test_enable_drop();
        test_reset_mid_write();
        test_bad_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
